memory_access: RTL and testbench

Memory-access pipeline stage between execute and write-back. It takes the registered execute result, performs byte/half/word loads and stores to data memory over a req/ack handshake, and stalls upstream while an access is outstanding. It presents the write-back result to the next stage and to the bypass network.

---
 rtl/memory_access_pkg.sv | 48 ++++
 rtl/memory_access_if.sv | 41 ++++
 rtl/memory_access_load_store_align.sv | 56 +++++
 rtl/memory_access.sv | 145 ++++++++++++++
 tb/tb_memory_access.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// Shared types for the memory-access pipeline stage: access width, destination
// control, FSM state, write-back register and the request hold register.
package memory_access_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } MemAccessWidth;

  typedef struct packed {
    logic       wEnable;
    logic [4:0] rdAddr;
    logic       forwardable;
  } RdCtrl;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } MemAccessState;

  typedef struct packed {
    logic [31:0] pc;
    RdCtrl       rdCtrl;
    logic [31:0] wbData;
  } WriteBackStagePipeReg;

  // Everything needed to replay an access to memory while the stage is busy.
  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   addr;
    logic [31:0]   wData;
    MemAccessWidth width;
    RdCtrl         rdCtrl;
    logic          isStore;
    logic          isUnsigned;
  } MemAccessHold;

  // A half must sit on an even byte, a word on a word boundary.
  function automatic logic is_misaligned(MemAccessWidth w, logic [1:0] off);
    case (w)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Stage bus: execute-side inputs, data-memory handshake and write-back outputs.
// slave = the memory-access stage, master = its environment.
interface memory_access_if;
  logic        inValid;
  logic [31:0] inPc;
  logic [31:0] inAluResult;
  logic [31:0] inWData;
  logic [1:0]  inMemAccessWidth;
  logic [6:0]  inRdCtrl;
  logic        inIsLoad;
  logic        inIsStore;
  logic        inIsLoadUnsigned;
  logic        stall;
  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWData;
  logic [3:0]  dmemBe;
  logic        dmemAck;
  logic [31:0] dmemRData;
  logic        outValid;
  logic [31:0] outPc;
  logic [6:0]  outRdCtrl;
  logic [31:0] outWbData;
  logic [31:0] bypassMemData;
  logic        misaligned;

  modport slave (
    input  inValid, inPc, inAluResult, inWData, inMemAccessWidth, inRdCtrl,
           inIsLoad, inIsStore, inIsLoadUnsigned, dmemAck, dmemRData,
    output stall, dmemReq, dmemWe, dmemAddr, dmemWData, dmemBe,
           outValid, outPc, outRdCtrl, outWbData, bypassMemData, misaligned
  );

  modport master (
    output inValid, inPc, inAluResult, inWData, inMemAccessWidth, inRdCtrl,
           inIsLoad, inIsStore, inIsLoadUnsigned, dmemAck, dmemRData,
    input  stall, dmemReq, dmemWe, dmemAddr, dmemWData, dmemBe,
           outValid, outPc, outRdCtrl, outWbData, bypassMemData, misaligned
  );
endinterface

// File: rtl/memory_access_load_store_align.sv
// load_store_align: combinational lane steering. Produces byte enables and
// replicated store data, and extracts/extends the addressed load value.
// Offset bits a half/word cannot use are dropped here.
module load_store_align
  import memory_access_pkg::*;
(
  input  MemAccessWidth width_i,
  input  logic [1:0]    off_i,
  input  logic [31:0]   wdata_i,
  input  logic [31:0]   rdata_i,
  input  logic          unsigned_i,
  output logic [3:0]    be_o,
  output logic [31:0]   wdata_o,
  output logic [31:0]   load_o
);

  logic [1:0]  eff_off;
  logic [31:0] shifted;
  logic        sign_fill;

  // Effective lane offset: halves keep only bit 1, words always start at lane 0.
  always_comb begin
    case (width_i)
      MEM_BYTE: eff_off = off_i;
      MEM_HALF: eff_off = {off_i[1], 1'b0};
      default:  eff_off = 2'b00;
    endcase
  end

  // Addressed byte/half moved down to bit 0.
  assign shifted = rdata_i >> {eff_off, 3'b000};

  // Enables, lane replication and load extension per width; word is the default.
  always_comb begin
    be_o      = 4'hF;
    wdata_o   = wdata_i;
    load_o    = shifted;
    sign_fill = 1'b0;
    case (width_i)
      MEM_BYTE: begin
        sign_fill = ~unsigned_i & shifted[7];
        be_o      = 4'b0001 << eff_off;
        wdata_o   = {4{wdata_i[7:0]}};
        load_o    = {{24{sign_fill}}, shifted[7:0]};
      end
      MEM_HALF: begin
        sign_fill = ~unsigned_i & shifted[15];
        be_o      = 4'b0011 << eff_off;
        wdata_o   = {2{wdata_i[15:0]}};
        load_o    = {{16{sign_fill}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and write-back. Non-memory ops
// pass through in one edge; loads/stores are captured, issued over the dmem
// req/ack handshake while the stage stalls upstream, and retired on the edge
// after ack. Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned half/word
// ops retire immediately with the misaligned flag instead of going to memory).
module memory_access
  import memory_access_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  memory_access_if.slave bus
);

  MemAccessState        state_q, state_d;
  MemAccessHold         hold_q, hold_d;
  WriteBackStagePipeReg wb_q, wb_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy;
  logic                 in_is_mem;
  RdCtrl                in_rd;
  logic [3:0]           lane_be;
  logic [31:0]          lane_wdata;
  logic [31:0]          load_value;

  assign busy      = (state_q == BUSY);
  assign in_is_mem = bus.inIsLoad | bus.inIsStore;
  assign in_rd     = RdCtrl'(bus.inRdCtrl);

  load_store_align u_align (
    .width_i    (hold_q.width),
    .off_i      (hold_q.addr[1:0]),
    .wdata_i    (hold_q.wData),
    .rdata_i    (bus.dmemRData),
    .unsigned_i (hold_q.isUnsigned),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .load_o     (load_value)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic in_misaligned;
  assign in_misaligned = is_misaligned(MemAccessWidth'(bus.inMemAccessWidth),
                                       bus.inAluResult[1:0]);
`endif

  // Next-state and next write-back value; outValid drops unless something retires.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    wb_d        = wb_q;
    out_valid_d = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          if (!in_is_mem) begin
            wb_d.pc     = bus.inPc;
            wb_d.rdCtrl = in_rd;
            wb_d.wbData = bus.inAluResult;
            out_valid_d = 1'b1;
          end
`ifdef MEM_MISALIGN_TRAP_EN
          else if (in_misaligned) begin
            wb_d.pc             = bus.inPc;
            wb_d.rdCtrl         = in_rd;
            wb_d.rdCtrl.wEnable = 1'b0;
            wb_d.wbData         = bus.inAluResult;
            out_valid_d         = 1'b1;
            mis_d               = 1'b1;
          end
`endif
          else begin
            hold_d.pc         = bus.inPc;
            hold_d.addr       = bus.inAluResult;
            hold_d.wData      = bus.inWData;
            hold_d.width      = MemAccessWidth'(bus.inMemAccessWidth);
            hold_d.rdCtrl     = in_rd;
            hold_d.isStore    = bus.inIsStore;
            hold_d.isUnsigned = bus.inIsLoadUnsigned;
            state_d           = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus.dmemAck) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          wb_d.pc     = hold_q.pc;
          wb_d.rdCtrl = hold_q.rdCtrl;
          if (hold_q.isStore) begin
            wb_d.rdCtrl.wEnable = 1'b0;
            wb_d.wbData         = hold_q.addr;
          end else begin
            wb_d.wbData = load_value;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, hold and write-back registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      wb_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wb_q        <= wb_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle misaligned flag accompanying the trapped result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= mis_d;
  end
  assign bus.misaligned = mis_q;
`else
  assign bus.misaligned = 1'b0;
`endif

  // dmem side is driven only while busy so it reads zero in IDLE and reset.
  assign bus.stall     = busy;
  assign bus.dmemReq   = busy;
  assign bus.dmemWe    = busy & hold_q.isStore;
  assign bus.dmemAddr  = busy ? {hold_q.addr[31:2], 2'b00} : 32'h0;
  assign bus.dmemWData = busy ? lane_wdata : 32'h0;
  assign bus.dmemBe    = busy ? lane_be : 4'h0;

  assign bus.outValid      = out_valid_q;
  assign bus.outPc         = wb_q.pc;
  assign bus.outRdCtrl     = wb_q.rdCtrl;
  assign bus.outWbData     = wb_q.wbData;
  assign bus.bypassMemData = wb_q.wbData;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: reset checks, a table of directed vectors, hand
// sequences for misaligned access / reset mid-access / back-to-back ops, and a
// randomized stream checked against a byte-level memory reference model.
module tb_memory_access;

  logic clk = 1'b0;
  logic rst = 1'b1;
  memory_access_if bus();

  memory_access dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          valid;
    logic [31:0] pc, alu, wd;
    logic [1:0]  width;
    logic [6:0]  rd;
    bit          ld, st, uns;
    int          delay;
  } instr_t;

  typedef struct {
    logic [31:0] alu, wd, rdata;
    logic [1:0]  width;
    logic [6:0]  rd;
    bit          ld, st, uns;
    int          delay;
    logic [31:0] exp_wb;
    logic [6:0]  exp_rd;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_busy;
  } vec_t;

  typedef struct { logic [31:0] pc, wb; logic [6:0] rd; bit mis; } res_t;
  typedef struct { logic [31:0] addr, wdata; logic [3:0] be; bit we; int delay; } acc_t;

  instr_t      prog[$];
  res_t        exp_q[$];
  acc_t        acc_q[$];
  logic [31:0] mem_words[16];   // memory responder
  logic [7:0]  ref_bytes[64];   // reference model's view of the same region
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i);
    bus.inValid          = i.valid;
    bus.inPc             = i.pc;
    bus.inAluResult      = i.alu;
    bus.inWData          = i.wd;
    bus.inMemAccessWidth = i.width;
    bus.inRdCtrl         = i.rd;
    bus.inIsLoad         = i.ld;
    bus.inIsStore        = i.st;
    bus.inIsLoadUnsigned = i.uns;
  endtask

  function automatic instr_t mk_instr(logic [31:0] pc, logic [31:0] alu, logic [31:0] wd,
                                      logic [1:0] width, logic [6:0] rd, bit ld, bit st,
                                      bit uns, int delay);
    instr_t i;
    i.valid = 1'b1; i.pc = pc; i.alu = alu; i.wd = wd; i.width = width; i.rd = rd;
    i.ld = ld; i.st = st; i.uns = uns; i.delay = delay;
    return i;
  endfunction

  function automatic vec_t mk_vec(logic [31:0] alu, logic [31:0] wd, logic [31:0] rdata,
                                  logic [1:0] width, logic [6:0] rd, bit ld, bit st, bit uns,
                                  int delay, logic [31:0] exp_wb, logic [6:0] exp_rd,
                                  logic [31:0] exp_addr, logic [3:0] exp_be,
                                  logic [31:0] exp_wdata, int exp_busy);
    vec_t v;
    v.alu = alu; v.wd = wd; v.rdata = rdata; v.width = width; v.rd = rd;
    v.ld = ld; v.st = st; v.uns = uns; v.delay = delay; v.exp_wb = exp_wb;
    v.exp_rd = exp_rd; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_busy = exp_busy;
    return v;
  endfunction

  // Reference model: instruction semantics over a byte array.
  task automatic model_issue(input instr_t i);
    res_t        r;
    acc_t        a;
    int          size, off, eff, base;
    logic [31:0] v;
    bit          st, ld;
    st = i.st;
    ld = i.ld && !i.st;
    r.pc = i.pc; r.rd = i.rd; r.wb = i.alu; r.mis = 1'b0;
    if (!(st || ld)) begin
      exp_q.push_back(r);
      return;
    end
    size = 1 << i.width;
    off  = int'(i.alu[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    if (off % size != 0) begin
      r.rd  = i.rd & 7'h3F;
      r.mis = 1'b1;
      exp_q.push_back(r);
      return;
    end
`endif
    eff     = off - (off % size);
    a.addr  = {i.alu[31:2], 2'b00};
    a.be    = 4'(((1 << size) - 1) << eff);
    a.wdata = (size == 1) ? 32'({24'h0, i.wd[7:0]} * 32'h01010101) :
              (size == 2) ? 32'({16'h0, i.wd[15:0]} * 32'h00010001) : i.wd;
    a.we    = st;
    a.delay = i.delay;
    acc_q.push_back(a);
    base = int'(i.alu[5:0]) - off + eff;
    if (st) begin
      for (int k = 0; k < size; k++) ref_bytes[(base + k) % 64] = i.wd[8*k +: 8];
      r.rd = i.rd & 7'h3F;
      r.wb = i.alu;
    end else begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(ref_bytes[(base + k) % 64]) << (8 * k));
      if (!i.uns && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      r.wb = v;
    end
    exp_q.push_back(r);
  endtask

  // One directed vector: present, serve the handshake, check the result.
  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    int busy_n;
    bit done;
    drive(mk_instr(pc, v.alu, v.wd, v.width, v.rd, v.ld, v.st, v.uns, v.delay));
    chk("vec_accept_stall", bus.stall, 0);
    tick();
    bus.inValid = 1'b0;
    busy_n = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.outValid) begin
        chk("vec_wb", bus.outWbData, v.exp_wb);
        chk("vec_bypass", bus.bypassMemData, v.exp_wb);
        chk("vec_rd", bus.outRdCtrl, v.exp_rd);
        chk("vec_pc", bus.outPc, pc);
        chk("vec_req_after", bus.dmemReq, 0);
        chk("vec_busy_cycles", busy_n, v.exp_busy);
        $display("vec pc=%h addr=%h wb=%h busy=%0d", pc, v.alu, bus.outWbData, busy_n);
        done = 1'b1;
      end else if (bus.dmemReq) begin
        chk("vec_stall", bus.stall, 1);
        chk("vec_addr", bus.dmemAddr, v.exp_addr);
        chk("vec_be", bus.dmemBe, v.exp_be);
        chk("vec_we", bus.dmemWe, v.st);
        if (v.st) chk("vec_wdata", bus.dmemWData, v.exp_wdata);
        bus.dmemRData = $urandom;
        if (busy_n == v.delay) begin
          bus.dmemAck   = 1'b1;
          bus.dmemRData = v.rdata;
        end
        busy_n++;
        tick();
        bus.dmemAck = 1'b0;
      end else begin
        fail("vec_stuck");
        done = 1'b1;
      end
    end
    if (!done) fail("vec_timeout");
  endtask

  // Streamed instructions with a memory responder; results checked in order.
  task automatic run_stream(input bit bubbles);
    res_t   r;
    acc_t   cur;
    instr_t ins;
    int     wait_n = 0, quiet = 0, idx;
    bit     in_req = 1'b0, prev_ack = 1'b0, done = 1'b0;
    bus.inValid = 1'b0;
    bus.dmemAck = 1'b0;
    tick();
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (bus.outValid) begin
        quiet = 0;
        if (exp_q.size() == 0) begin
          fail("stream_extra_result");
        end else begin
          r = exp_q.pop_front();
          chk("stream_pc", bus.outPc, r.pc);
          chk("stream_rd", bus.outRdCtrl, r.rd);
          chk("stream_wb", bus.outWbData, r.wb);
          chk("stream_bypass", bus.bypassMemData, r.wb);
          chk("stream_mis", bus.misaligned, r.mis);
          $display("stream pc=%h rd=%h wb=%h", bus.outPc, bus.outRdCtrl, bus.outWbData);
        end
      end else if (exp_q.size() != 0) begin
        quiet++;
        if (quiet > 64) begin
          fail("stream_no_result");
          done = 1'b1;
        end
      end
      bus.dmemAck   = 1'b0;
      bus.dmemRData = $urandom;
      if (prev_ack) chk("stream_req_low_after_ack", bus.dmemReq, 0);
      prev_ack = 1'b0;
      if (bus.dmemReq && !done) begin
        if (!in_req) begin
          if (acc_q.size() == 0) begin
            fail("stream_extra_req");
            done = 1'b1;
          end else begin
            cur    = acc_q.pop_front();
            in_req = 1'b1;
            wait_n = 0;
          end
        end
        if (in_req) begin
          chk("stream_addr", bus.dmemAddr, cur.addr);
          chk("stream_be", bus.dmemBe, cur.be);
          chk("stream_we", bus.dmemWe, cur.we);
          if (cur.we) chk("stream_wdata", bus.dmemWData, cur.wdata);
          chk("stream_stall", bus.stall, 1);
          if (wait_n == cur.delay) begin
            idx           = int'(bus.dmemAddr[5:2]);
            bus.dmemAck   = 1'b1;
            bus.dmemRData = mem_words[idx];
            if (bus.dmemWe)
              for (int b = 0; b < 4; b++)
                if (bus.dmemBe[b]) mem_words[idx][8*b +: 8] = bus.dmemWData[8*b +: 8];
            in_req   = 1'b0;
            prev_ack = 1'b1;
          end
          wait_n++;
        end
      end
      if (!bus.stall) begin
        if (prog.size() != 0 && (!bubbles || $urandom_range(0, 3) != 0)) begin
          ins = prog.pop_front();
          drive(ins);
          model_issue(ins);
        end else begin
          bus.inValid = 1'b0;
        end
      end
      if (prog.size() == 0 && exp_q.size() == 0 && acc_q.size() == 0 && !in_req) done = 1'b1;
      if (!done) tick();
    end
    if (!done) fail("stream_timeout");
    bus.inValid = 1'b0;
    bus.dmemAck = 1'b0;
    prog.delete();
    exp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t      ri;
    int          kind;
    logic [31:0] pc;

    bus.inValid = 1'b0; bus.inPc = '0; bus.inAluResult = '0; bus.inWData = '0;
    bus.inMemAccessWidth = '0; bus.inRdCtrl = '0; bus.inIsLoad = 1'b0;
    bus.inIsStore = 1'b0; bus.inIsLoadUnsigned = 1'b0;
    bus.dmemAck = 1'b0; bus.dmemRData = '0;
    for (int w = 0; w < 16; w++) begin
      mem_words[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = mem_words[w][8*b +: 8];
    end

    // Reset state, observed before any clock edge.
    #2 rst = 1'b0;
    #2;
    chk("rst_stall", bus.stall, 0);
    chk("rst_req", bus.dmemReq, 0);
    chk("rst_outvalid", bus.outValid, 0);
    chk("rst_wb", bus.outWbData, 0);
    chk("rst_rd", bus.outRdCtrl, 0);
    chk("rst_mis", bus.misaligned, 0);
    chk("rst_be", bus.dmemBe, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_outvalid", bus.outValid, 0);

    // Directed table.
    vecs[0] = mk_vec(32'h1234, 0, 0, 2'd2, 7'h47, 0, 0, 0, 0, 32'h1234, 7'h47, 0, 0, 0, 0);
    vecs[1] = mk_vec(32'h103, 0, 32'h80FFFF00, 2'd0, 7'h4A, 1, 0, 0, 0, 32'hFFFFFF80, 7'h4A, 32'h100, 4'h8, 0, 1);
    vecs[2] = mk_vec(32'h103, 0, 32'h80FFFF00, 2'd0, 7'h4A, 1, 0, 1, 0, 32'h00000080, 7'h4A, 32'h100, 4'h8, 0, 1);
    vecs[3] = mk_vec(32'h102, 32'hABCD, 0, 2'd1, 7'h4A, 0, 1, 0, 3, 32'h102, 7'h0A, 32'h100, 4'hC, 32'hABCDABCD, 4);
    vecs[4] = mk_vec(32'h106, 0, 32'h80017FFF, 2'd1, 7'h4A, 1, 0, 0, 1, 32'hFFFF8001, 7'h4A, 32'h104, 4'hC, 0, 2);
    vecs[5] = mk_vec(32'h108, 0, 32'hDEADBEEF, 2'd2, 7'h4B, 1, 0, 0, 0, 32'hDEADBEEF, 7'h4B, 32'h108, 4'hF, 0, 1);
    vecs[6] = mk_vec(32'h101, 32'h1234565A, 0, 2'd0, 7'h4A, 0, 1, 0, 0, 32'h101, 7'h0A, 32'h100, 4'h2, 32'h5A5A5A5A, 1);
    vecs[7] = mk_vec(32'h10C, 32'hCAFEF00D, 0, 2'd2, 7'h7F, 1, 1, 0, 2, 32'h10C, 7'h3F, 32'h10C, 4'hF, 32'hCAFEF00D, 3);
    vecs[8] = mk_vec(32'hFFFFFFFF, 0, 0, 2'd0, 7'h3E, 0, 0, 0, 0, 32'hFFFFFFFF, 7'h3E, 0, 0, 0, 0);
    vecs[9] = mk_vec(32'h104, 0, 32'h1234F00D, 2'd1, 7'h4A, 1, 0, 1, 0, 32'h0000F00D, 7'h4A, 32'h104, 4'h3, 0, 1);
    for (int i = 0; i < 10; i++) run_vec(vecs[i], 32'h4000 + 32'(4 * i));

    // Word load at a misaligned address.
    drive(mk_instr(32'h5000, 32'h101, 0, 2'd2, 7'h4A, 1, 0, 0, 0));
    tick();
    bus.inValid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_no_req", bus.dmemReq, 0);
    chk("mis_outvalid", bus.outValid, 1);
    chk("mis_flag", bus.misaligned, 1);
    chk("mis_rd", bus.outRdCtrl, 7'h0A);
    chk("mis_wb", bus.outWbData, 32'h101);
    tick();
    chk("mis_flag_clear", bus.misaligned, 0);
    chk("mis_outvalid_clear", bus.outValid, 0);
`else
    chk("mask_req", bus.dmemReq, 1);
    chk("mask_addr", bus.dmemAddr, 32'h100);
    chk("mask_be", bus.dmemBe, 4'hF);
    bus.dmemAck = 1'b1;
    bus.dmemRData = 32'h11223344;
    tick();
    bus.dmemAck = 1'b0;
    chk("mask_outvalid", bus.outValid, 1);
    chk("mask_wb", bus.outWbData, 32'h11223344);
    chk("mask_mis", bus.misaligned, 0);
`endif
    $display("misaligned word load at 0x101 done");

    // Reset asserted while an access is outstanding.
    tick();
    drive(mk_instr(32'h6000, 32'h100, 0, 2'd2, 7'h4A, 1, 0, 0, 0));
    tick();
    bus.inValid = 1'b0;
    chk("rmid_req_before", bus.dmemReq, 1);
    #2 rst = 1'b0;
    #1;
    chk("rmid_req_drop", bus.dmemReq, 0);
    chk("rmid_stall_drop", bus.stall, 0);
    @(posedge clk);
    #1;
    chk("rmid_outvalid", bus.outValid, 0);
    rst = 1'b1;
    tick();
    chk("rmid_idle_outvalid", bus.outValid, 0);
    chk("rmid_idle_req", bus.dmemReq, 0);
    // Stray ack while idle must do nothing.
    bus.dmemAck = 1'b1;
    tick();
    bus.dmemAck = 1'b0;
    chk("idle_ack_outvalid", bus.outValid, 0);
    chk("idle_ack_req", bus.dmemReq, 0);
    $display("reset mid-access done");
    run_vec(vecs[0], 32'h6004);

    // Back-to-back: load (ack at once), load (ack after 2), ALU op.
    prog.push_back(mk_instr(32'h7000, 32'h104, 0, 2'd2, 7'h45, 1, 0, 0, 0));
    prog.push_back(mk_instr(32'h7004, 32'h10B, 0, 2'd0, 7'h46, 1, 0, 0, 2));
    prog.push_back(mk_instr(32'h7008, 32'h55, 0, 2'd0, 7'h47, 0, 0, 0, 0));
    run_stream(1'b0);

    // Randomized stream.
    pc = 32'h8000;
    for (int n = 0; n < 250; n++) begin
      kind = int'($urandom_range(0, 2));
      ri = mk_instr(pc, 32'h100 + 32'($urandom_range(0, 63)), $urandom,
                    2'($urandom_range(0, 2)), 7'($urandom), kind == 1, kind == 2,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      if (kind == 0) ri.alu = $urandom;
      if (kind == 2 && $urandom_range(0, 7) == 0) ri.ld = 1'b1;
      prog.push_back(ri);
      pc = pc + 32'd4;
    end
    run_stream(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
